// File: rtl/moa_rr_sched_if.sv
// Request/result bundle for the round-robin operand-sum scheduler.
// master drives requests and accepts results; slave is the scheduler.
interface moa_rr_sched_if;
   logic [3:0]   req_valid;
   logic [255:0] req_data;
   logic [3:0]   req_ready;
   logic         res_valid;
   logic         res_ready;
   logic [1:0]   res_id;
   logic [10:0]  res_sum;
   logic         busy;

   modport master (
      output req_valid,
      output req_data,
      output res_ready,
      input  req_ready,
      input  res_valid,
      input  res_id,
      input  res_sum,
      input  busy
   );

   modport slave (
      input  req_valid,
      input  req_data,
      input  res_ready,
      output req_ready,
      output res_valid,
      output res_id,
      output res_sum,
      output busy
   );
endinterface

// File: rtl/moa_rr_sched.sv
// Four requesters share one 8-byte adder through a round-robin grant;
// sums land in a small result FIFO guarded by a credit check.
module moa_rr_sched #(
   parameter int OUT_DEPTH = 4
) (
   input logic           clk,
   input logic           rst_n,
   moa_rr_sched_if.slave bus
);
   localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(OUT_DEPTH);

   logic [1:0]    rr_ptr;
   logic [1:0]    gnt_idx;
   logic [1:0]    idx;
   logic          found;
   logic          credit;
   logic          hs;
   logic [3:0]    grant;

   logic          s1_valid;
   logic [1:0]    s1_id;
   logic [63:0]   s1_data;
   logic [10:0]   s1_sum;

   logic [CW-1:0] fifo_count;
   logic [CW:0]   occ;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [12:0]   mem [OUT_DEPTH];
   logic          nempty;
   logic          push;
   logic          pop;

   // Stage-1 occupancy counts against the FIFO; a same-cycle pop is ignored.
   always_comb begin
      occ    = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid};
      credit = occ < DEPTH_L;
   end

   always_comb begin
      idx     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      grant   = '0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_ptr + 2'(k);
         if (!found && bus.req_valid[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
      if (found && credit && rst_n)
         grant[gnt_idx] = 1'b1;
   end

   assign hs            = |grant;
   assign bus.req_ready = grant;

   always_comb begin
      s1_sum = '0;
      for (int i = 0; i < 8; i++)
         s1_sum = s1_sum + {3'b000, s1_data[8*i +: 8]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr   <= '0;
         s1_valid <= 1'b0;
         s1_id    <= '0;
         s1_data  <= '0;
      end else begin
         s1_valid <= hs;
         if (hs) begin
            rr_ptr  <= gnt_idx + 2'd1;
            s1_id   <= gnt_idx;
            s1_data <= bus.req_data[{gnt_idx, 6'd0} +: 64];
         end
      end
   end

   assign nempty = fifo_count != '0;
   assign push   = s1_valid;
   assign pop    = nempty && bus.res_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < OUT_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {s1_id, s1_sum};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Head fields are masked when empty so they read zero in reset.
   assign bus.res_valid = nempty;
   assign bus.res_id    = nempty ? mem[rd_ptr][12:11] : 2'd0;
   assign bus.res_sum   = nempty ? mem[rd_ptr][10:0] : 11'd0;
   assign bus.busy      = s1_valid | nempty;
endmodule
